k580vt57_dma: RTL

- 4-channel DMA controller in the style of the 8257.
- Serves the drq requests raised by the CRT controller and other peripherals. Arbitrates for the CPU bus with hrq/hlda, then drives the memory address and strobes. Returns dack to the requester so it latches the bus byte (ichar at the CRT).
- Channel 2 with autoload from channel 3 provides the frame-by-frame screen refresh.

---
 rtl/k580vt57_dma_if.sv | 32 +++
 rtl/k580vt57_dma.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/k580vt57_dma_if.sv
// Bundles the CPU register port, the DMA request/acknowledge pairs, the bus hold
// handshake and the memory/I-O strobe bus of the k580vt57 DMA controller.
// Latency: wires only. Backpressure: none; hlda gates the DMA side of the bus.
// master: the DMA controller. slave: the system side (CPU, peripherals, memory).
interface k580vt57_dma_if;
  logic [3:0]  iaddr;    // CPU register select
  logic [7:0]  idata;    // CPU write data
  logic [7:0]  odata;    // CPU read data
  logic        iwe_n;    // CPU write strobe, acts on its rising edge
  logic        ird_n;    // CPU read strobe, side effects on its rising edge
  logic [3:0]  drq;      // per-channel request, level sensitive
  logic [3:0]  dack;     // per-channel acknowledge, one-hot
  logic        hrq;      // hold request to CPU
  logic        hlda;     // hold acknowledge from CPU
  logic [15:0] oaddr;    // DMA memory address
  logic        omemr_n;
  logic        omemw_n;
  logic        oior_n;
  logic        oiow_n;
  logic        tc;       // terminal count, valid with strobes
  logic        mark;     // 128-byte mark, valid with strobes

  modport master (
    input  iaddr, idata, iwe_n, ird_n, drq, hlda,
    output odata, dack, hrq, oaddr, omemr_n, omemw_n, oior_n, oiow_n, tc, mark
  );

  modport slave (
    output iaddr, idata, iwe_n, ird_n, drq, hlda,
    input  odata, dack, hrq, oaddr, omemr_n, omemw_n, oior_n, oiow_n, tc, mark
  );
endinterface

// File: rtl/k580vt57_dma.sv
// 4-channel 8257-style DMA controller: per-channel address/count, fixed or rotating priority, autoload ch3->ch2.
// Latency: hrq one clk after a request; each transfer is S1..S4, 4 clk, 1 byte per 4 clk in burst.
// Backpressure: waits in S0 for hlda; a dropped hlda or request ends the burst after the current cycle.
// Ports: clk, rst_n (async active-low); bus (master modport) carries the CPU register port,
// drq/dack, hrq/hlda and the address/strobe/tc/mark outputs.
module k580vt57_dma (
  input  logic            clk,
  input  logic            rst_n,
  k580vt57_dma_if.master  bus
);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_S0   = 3'd1,
    ST_S1   = 3'd2,
    ST_S2   = 3'd3,
    ST_S3   = 3'd4,
    ST_S4   = 3'd5
  } state_t;

  state_t           state_q, state_d;
  logic [3:0][15:0] addr_q, addr_d;
  logic [3:0][15:0] cnt_q, cnt_d;
  logic [7:0]       mode_q, mode_d;
  logic [3:0]       tcf_q, tcf_d;
  logic             upd_q, upd_d;
  logic             ff_q, ff_d;
  logic [1:0]       ch_q, ch_d;
  logic [1:0]       prio_q, prio_d;
  logic             iwe_q, ird_q;

  logic             wr_stb, rd_stb;
  logic [3:0]       req;
  logic [3:0]       req_next;
  logic [1:0]       wsel;
  logic             last;
  logic [15:0]      rd_reg;
  logic             rd_lo, wr_lo;
  logic [1:0]       typ;

  // Strobes are sampled in clk; the action happens on the low-to-high transition.
  assign wr_stb = bus.iwe_n & ~iwe_q;
  assign rd_stb = bus.ird_n & ~ird_q;
  assign req    = bus.drq & mode_q[3:0];

  // First requesting channel scanning upward (mod 4) from base.
  function automatic logic [1:0] pick(input logic [3:0] r, input logic [1:0] base);
    logic [1:0] res;
    logic [1:0] cand;
    logic       found;
    res   = base;
    found = 1'b0;
    for (int i = 3; i >= 0; i--) begin
      cand = base + 2'(i);
      if (r[cand]) begin
        res   = cand;
        found = 1'b1;
      end
    end
    if (!found) res = base;
    return res;
  endfunction

  // CPU read mux
  always_comb begin
    bus.odata = 8'h00;
    rd_reg    = 16'h0000;
    if (!bus.iaddr[3]) begin
      rd_reg    = bus.iaddr[0] ? cnt_q[bus.iaddr[2:1]] : addr_q[bus.iaddr[2:1]];
      bus.odata = ff_q ? rd_reg[15:8] : rd_reg[7:0];
    end else if (bus.iaddr == 4'h8) begin
      bus.odata = {3'b000, upd_q, tcf_q};
    end
  end

  // Next state: CPU register accesses first, then the S4 bookkeeping so that
  // the channel update overrides a same-clk CPU write to that channel.
  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    cnt_d    = cnt_q;
    mode_d   = mode_q;
    tcf_d    = tcf_q;
    upd_d    = upd_q;
    ff_d     = ff_q;
    ch_d     = ch_q;
    prio_d   = prio_q;
    wsel     = bus.iaddr[2:1];
    last     = 1'b0;
    req_next = 4'h0;

    if (wr_stb) begin
      if (!bus.iaddr[3]) begin
        if (bus.iaddr[0]) begin
          if (ff_q) cnt_d[wsel][15:8] = bus.idata;
          else      cnt_d[wsel][7:0]  = bus.idata;
        end else begin
          if (ff_q) addr_d[wsel][15:8] = bus.idata;
          else      addr_d[wsel][7:0]  = bus.idata;
        end
        // Autoload mode mirrors channel-2 programming into channel 3.
        if (mode_q[7] && wsel == 2'd2) begin
          if (bus.iaddr[0]) begin
            if (ff_q) cnt_d[3][15:8] = bus.idata;
            else      cnt_d[3][7:0]  = bus.idata;
          end else begin
            if (ff_q) addr_d[3][15:8] = bus.idata;
            else      addr_d[3][7:0]  = bus.idata;
          end
        end
        ff_d = ~ff_q;
      end else if (bus.iaddr == 4'h8) begin
        mode_d = bus.idata;
        ff_d   = 1'b0;
      end
    end

    if (rd_stb) begin
      if (!bus.iaddr[3])            ff_d  = ~ff_q;
      else if (bus.iaddr == 4'h8)   tcf_d = 4'h0;
    end

    unique case (state_q)
      ST_IDLE: if (|req) state_d = ST_S0;
      ST_S0: begin
        if (!(|req)) begin
          state_d = ST_IDLE;
        end else if (bus.hlda) begin
          ch_d    = pick(req, mode_q[4] ? prio_q : 2'd0);
          state_d = ST_S1;
        end
      end
      ST_S1: state_d = ST_S2;
      ST_S2: state_d = ST_S3;
      ST_S3: state_d = ST_S4;
      ST_S4: begin
        last           = (cnt_q[ch_q][13:0] == 14'd0);
        addr_d[ch_q]   = addr_q[ch_q] + 16'd1;
        cnt_d[ch_q]    = {cnt_q[ch_q][15:14], cnt_q[ch_q][13:0] - 14'd1};
        if (mode_q[4]) prio_d = ch_q + 2'd1;
        if (ch_q == 2'd2) upd_d = 1'b0;
        if (last) begin
          tcf_d[ch_q] = 1'b1;
          if (mode_q[6]) mode_d[ch_q] = 1'b0;
          if (ch_q == 2'd2 && mode_q[7]) begin
            addr_d[2] = addr_q[3];
            cnt_d[2]  = cnt_q[3];
            upd_d     = 1'b1;
          end
        end
        // Re-arbitrate against the post-cycle enables so a TC-stopped channel is not served again.
        req_next = bus.drq & mode_d[3:0];
        if ((|req_next) && bus.hlda) begin
          ch_d    = pick(req_next, mode_q[4] ? (ch_q + 2'd1) : 2'd0);
          state_d = ST_S1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      cnt_q   <= '0;
      mode_q  <= 8'h00;
      tcf_q   <= 4'h0;
      upd_q   <= 1'b0;
      ff_q    <= 1'b0;
      ch_q    <= 2'd0;
      prio_q  <= 2'd0;
      iwe_q   <= 1'b1;
      ird_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
      tcf_q   <= tcf_d;
      upd_q   <= upd_d;
      ff_q    <= ff_d;
      ch_q    <= ch_d;
      prio_q  <= prio_d;
      iwe_q   <= bus.iwe_n;
      ird_q   <= bus.ird_n;
    end
  end

  // Bus outputs decode straight from the registered state, so reset releases them at once.
  always_comb begin
    bus.hrq   = (state_q != ST_IDLE);
    bus.dack  = 4'h0;
    bus.oaddr = 16'h0000;
    bus.tc    = 1'b0;
    bus.mark  = 1'b0;
    rd_lo     = 1'b0;
    wr_lo     = 1'b0;
    typ       = cnt_q[ch_q][15:14];

    if (state_q == ST_S1 || state_q == ST_S2 || state_q == ST_S3 || state_q == ST_S4)
      bus.oaddr = addr_q[ch_q];
    if (state_q == ST_S1 || state_q == ST_S2 || state_q == ST_S3)
      bus.dack[ch_q] = 1'b1;
    if (state_q == ST_S2 || state_q == ST_S3) begin
      rd_lo     = 1'b1;
      wr_lo     = (state_q == ST_S3) || mode_q[5];
      bus.tc    = (cnt_q[ch_q][13:0] == 14'd0);
      bus.mark  = (cnt_q[ch_q][6:0] == 7'd0) && (cnt_q[ch_q][13:0] != 14'd0);
    end

    // Type 01: I/O -> memory; type 10: memory -> I/O; 00/11 verify, no strobes.
    bus.oior_n  = ~(rd_lo && typ == 2'b01);
    bus.omemw_n = ~(wr_lo && typ == 2'b01);
    bus.omemr_n = ~(rd_lo && typ == 2'b10);
    bus.oiow_n  = ~(wr_lo && typ == 2'b10);
  end

endmodule
